// File: rtl/keypad_emulator.sv
// keypad_emulator: drive end of a 4x4 active-low keypad matrix.
// Key codes arrive over a valid/ready handshake and are queued in a FIFO.
// Each queued key is replayed as a timed press followed by a forced release.
// RowIn answers the scanner's ColOut combinationally, the way a real switch does.
// Build option: define KEYPAD_EMU_BOUNCE_EN to make the contact bounce
// deterministically at the start of each press and each release.
module keypad_emulator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESS_CYCLES   = 16,
  parameter int RELEASE_CYCLES = 16,
  parameter int BOUNCE_CYCLES  = 4
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  output logic                          key_ready,
  input  logic [3:0]                    ColOut,
  output logic [3:0]                    RowIn,
  output logic                          pressing,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CW      = PTR_W + 1;
  localparam int CNT_MAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]    DEPTH_C      = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    COUNT_ONE    = CW'(1);
  localparam logic [CW-1:0]    COUNT_ZERO   = CW'(0);
  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO     = PTR_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);

  // Length of the bouncing window at the start of each phase.
  // With bounce disabled the window is empty, so press is solidly closed
  // and release solidly open.
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BOUNCE_W = BOUNCE_CYCLES;
`else
  localparam int BOUNCE_W = BOUNCE_CYCLES * 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Contact state at a given offset into PRESS: bounces on odd offsets
  // inside the window, closed otherwise.
  function automatic logic press_contact(input int off);
    return (off >= BOUNCE_W) || (off[0] == 1'b0);
  endfunction

  // Contact state at a given offset into RELEASE: closed on even offsets
  // inside the window, open otherwise.
  function automatic logic release_contact(input int off);
    return (off < BOUNCE_W) && (off[0] == 1'b0);
  endfunction

  logic [3:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CW-1:0]    count_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       cur_key_r;
  logic             contact_r;

  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic [3:0]       row_s;

  // Handshake and queue control decoded from registered state.
  always_comb begin
    ready_s = (count_r < DEPTH_C);
    push_s  = key_valid && ready_s;
    pop_s   = (state_r == ST_IDLE) && (count_r != COUNT_ZERO);
  end

  // Queue storage; contents are only meaningful below count_r, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= key_code;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Press/release sequencer; contact_r is loaded with the next cycle's contact.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      cur_key_r <= 4'h0;
      contact_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            cur_key_r <= mem_r[rd_ptr_r];
            cnt_r     <= PRESS_LOAD;
            state_r   <= ST_PRESS;
            contact_r <= press_contact(0);
          end else begin
            contact_r <= 1'b0;
          end
        end
        ST_PRESS: begin
          if (cnt_r == CNT_ZERO) begin
            cnt_r     <= RELEASE_LOAD;
            state_r   <= ST_RELEASE;
            contact_r <= release_contact(0);
          end else begin
            cnt_r     <= cnt_r - CNT_ONE;
            contact_r <= press_contact(PRESS_CYCLES - int'(cnt_r));
          end
        end
        ST_RELEASE: begin
          if (cnt_r == CNT_ZERO) begin
            state_r   <= ST_IDLE;
            contact_r <= 1'b0;
          end else begin
            cnt_r     <= cnt_r - CNT_ONE;
            contact_r <= release_contact(RELEASE_CYCLES - int'(cnt_r));
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= CNT_ZERO;
          contact_r <= 1'b0;
        end
      endcase
    end
  end

  // Switch model: the key's row is pulled low only while its column is scanned.
  always_comb begin
    row_s = 4'b1111;
    if (contact_r && (ColOut[cur_key_r[1:0]] == 1'b0)) begin
      row_s[cur_key_r[3:2]] = 1'b0;
    end else begin
      row_s = 4'b1111;
    end
  end

  assign RowIn      = row_s;
  assign pressing   = contact_r;
  assign key_ready  = ready_s;
  assign busy       = (state_r != ST_IDLE) || (count_r != COUNT_ZERO);
  assign fifo_count = count_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator (default parameters).
// The clean-contact scenarios run in the default build; the bounce pattern
// scenario runs when KEYPAD_EMU_BOUNCE_EN is defined.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       RST;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] ColOut;
  logic [3:0] RowIn;
  logic       pressing;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  logic       log_en = 1'b0;
  logic       prev_press = 1'b0;
  logic [3:0] press_log[$];

  int         first, cnt, last, bdrop, bad, mism, lows, g, idx;
  logic [3:0] expv;
  logic [3:0] trace [100];
  logic [2:0] fc0, fc1, fc2;
  int         acc [5];
  logic [3:0] codes [5];
  logic [3:0] rot [4];
  logic [3:0] exp_rows [6];
  logic       rdy;

  keypad_emulator #(
    .FIFO_DEPTH    (4),
    .PRESS_CYCLES  (16),
    .RELEASE_CYCLES(16),
    .BOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .ColOut    (ColOut),
    .RowIn     (RowIn),
    .pressing  (pressing),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Log RowIn at the first cycle of every press while logging is enabled.
  always @(negedge clk) begin
    prev_press <= pressing;
    if (log_en && pressing && !prev_press) press_log.push_back(RowIn);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] code);
    int w;
    key_valid = 1'b1;
    key_code  = code;
    w = 0;
    while (!key_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("push_wait", (w < 200), 1);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rot      = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    codes    = '{4'h4, 4'h8, 4'hC, 4'h1, 4'h6};
    exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    RST = 1'b1; key_valid = 1'b0; key_code = 4'h0; ColOut = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
    check("rst_rowin",    RowIn, 4'b1111);
    check("rst_pressing", pressing, 0);
    check("rst_busy",     busy, 0);
    check("rst_ready",    key_ready, 1);
    check("rst_count",    fifo_count, 0);

`ifndef KEYPAD_EMU_BOUNCE_EN
    // Single key 0x6 (row 1, col 2) with its column scanned.
    ColOut = 4'b1011;
    push(4'h6);
    check("t1_rowin_before", RowIn, 4'b1111);
    check("t1_press_before", pressing, 0);
    check("t1_count",        fifo_count, 1);
    check("t1_busy",         busy, 1);
    first = -1; cnt = 0; last = -1; bdrop = -1; bad = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (RowIn == 4'b1101) begin
        if (first < 0) first = i;
        cnt++;
        last = i;
      end else if (RowIn != 4'b1111) begin
        bad++;
      end
      if (!busy && bdrop < 0) bdrop = i;
    end
    check("t1_first",     first, 1);
    check("t1_len",       cnt, 16);
    check("t1_last",      last, 16);
    check("t1_other_row", bad, 0);
    check("t1_busy_drop", bdrop - last, 17);

    // Column not scanned: rows stay high although the contact closes.
    wait_idle();
    ColOut = 4'b1110;
    push(4'h6);
    cnt = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pressing) cnt++;
      if (RowIn != 4'b1111) bad++;
    end
    check("t2_rows_high", bad, 0);
    check("t2_press_len", cnt, 16);

    // Rotating one-hot-low scan: row 1 answers only in the 1011 phase.
    wait_idle();
    ColOut = 4'b1111;
    push(4'h6);
    mism = 0; lows = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      ColOut = rot[i % 4];
      #1;
      expv = (i <= 16 && ColOut == 4'b1011) ? 4'b1101 : 4'b1111;
      if (RowIn !== expv) mism++;
      if (!RowIn[1]) lows++;
    end
    check("t2_rot_mism", mism, 0);
    check("t2_rot_lows", lows, 4);

    // Ordering of three back-to-back keys with every column scanned.
    wait_idle();
    ColOut = 4'b0000;
    key_valid = 1'b1;
    key_code  = 4'h0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      trace[t] = RowIn;
      if (t == 0) begin fc0 = fifo_count; key_code = 4'hF; end
      if (t == 1) begin fc1 = fifo_count; key_code = 4'h5; end
      if (t == 2) begin fc2 = fifo_count; key_valid = 1'b0; end
    end
    mism = 0;
    for (int t = 0; t < 100; t++) begin
      expv = 4'b1111;
      if (t >= 1  && t <= 16) expv = 4'b1110;
      if (t >= 34 && t <= 49) expv = 4'b0111;
      if (t >= 67 && t <= 82) expv = 4'b1101;
      if (trace[t] !== expv) mism++;
    end
    check("t3_count_push",    fc0, 1);
    check("t3_count_pushpop", fc1, 1);
    check("t3_count_two",     fc2, 2);
    check("t3_trace_mism",    mism, 0);
    check("t3_k0_start",      trace[1], 4'b1110);
    check("t3_gap_end",       trace[33], 4'b1111);
    check("t3_kF_start",      trace[34], 4'b0111);
    check("t3_k5_end",        trace[82], 4'b1101);
    check("t3_after_k5",      trace[83], 4'b1111);

    // Backpressure: four queue, the fifth waits for the next pop.
    wait_idle();
    ColOut = 4'b0000;
    press_log.delete();
    log_en = 1'b1;
    push(4'h0);
    g = 0;
    while (!pressing && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("t4_press_wait", pressing, 1);
    for (int k = 0; k < 5; k++) acc[k] = -1;
    idx = 0;
    key_valid = 1'b1;
    key_code  = codes[0];
    for (int t = 0; t < 100 && idx < 5; t++) begin
      rdy = key_ready;
      if (t == 4) begin
        check("t4_full_count", fifo_count, 4);
        check("t4_full_ready", key_ready, 0);
      end
      @(negedge clk);
      if (rdy) begin
        acc[idx] = t;
        idx++;
        if (idx < 5) key_code = codes[idx];
        else key_valid = 1'b0;
      end
    end
    key_valid = 1'b0;
    check("t4_acc_fourth", acc[3], 3);
    check("t4_acc_fifth",  acc[4], 33);
    wait_idle();
    log_en = 1'b0;
    check("t4_log_size", press_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t4_order%0d", k), (k < press_log.size()) ? press_log[k] : 4'h0, exp_rows[k]);
    end

    // Reset in the middle of a press with two keys waiting.
    wait_idle();
    ColOut = 4'b0000;
    push(4'h9);
    push(4'hA);
    push(4'hB);
    check("t5_pre_count", fifo_count, 2);
    check("t5_pre_press", pressing, 1);
    repeat (3) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check("t5_rowin",    RowIn, 4'b1111);
    check("t5_pressing", pressing, 0);
    check("t5_count",    fifo_count, 0);
    check("t5_ready",    key_ready, 1);
    check("t5_busy",     busy, 0);
    push(4'h3);
    cnt = 0; first = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) check("t5_new_row", RowIn, 4'b1110);
      if (pressing) cnt++;
    end
    check("t5_new_len", cnt, 16);
`else
    // Bounce pattern on key 0x6 with its column scanned.
    ColOut = 4'b1011;
    push(4'h6);
    mism = 0; cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      expv[0] = (i == 2 || i == 4 || i == 18 || i == 20 || i >= 21) ? 1'b1 : 1'b0;
      if (RowIn[1] !== expv[0]) mism++;
      if (pressing) cnt++;
      if (i == 1)  check("t6_p0",  RowIn[1], 0);
      if (i == 2)  check("t6_p1",  RowIn[1], 1);
      if (i == 3)  check("t6_p2",  RowIn[1], 0);
      if (i == 4)  check("t6_p3",  RowIn[1], 1);
      if (i == 5)  check("t6_p4",  RowIn[1], 0);
      if (i == 16) check("t6_p15", RowIn[1], 0);
      if (i == 17) check("t6_r0",  RowIn[1], 0);
      if (i == 18) check("t6_r1",  RowIn[1], 1);
      if (i == 19) check("t6_r2",  RowIn[1], 0);
      if (i == 20) check("t6_r3",  RowIn[1], 1);
      if (i == 21) check("t6_r4",  RowIn[1], 1);
    end
    check("t6_mism",         mism, 0);
    check("t6_closed_count", cnt, 16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
